// File: rtl/lfsr16_stream_ctrl.sv
// rtl/lfsr16_stream_ctrl.sv - bounded, flow-controlled 16-bit Fibonacci LFSR bit source
// Seeds the LFSR, produces nbits output bits and packs them MSB-first into WORD_W-bit stream words.
module lfsr16_stream_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       seed,
    input  logic [CNT_W-1:0]  nbits,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [15:0]       lfsr_state,
    output logic              period_wrap
);

    localparam int PK_W = $clog2(WORD_W) + 1;
    localparam logic [PK_W-1:0] PK_LAST = PK_W'(WORD_W - 1);
    localparam logic [PK_W-1:0] PK_FULL = PK_W'(WORD_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [15:0]       loaded_seed;
    logic [CNT_W-1:0]  remaining;
    logic [PK_W-1:0]   pk_cnt;
    logic [WORD_W-1:0] pack;

    logic              out_bit;
    logic              fb;
    logic [15:0]       lfsr_next;
    logic [15:0]       seed_eff;
    logic [WORD_W:0]   pack_shift;
    logic [WORD_W-1:0] pack_next;
    logic [WORD_W-1:0] flush_word;
    logic              word_full;
    logic              out_free;
    logic              advance;

    // lfsr_state[15] is s[16]; taps s16,s15,s13,s4 map to bits 15,14,12,3.
    assign out_bit   = lfsr_state[15];
    assign fb        = lfsr_state[15] ^ lfsr_state[14] ^ lfsr_state[12] ^ lfsr_state[3];
    assign lfsr_next = {lfsr_state[14:0], fb};
    assign seed_eff  = (seed == 16'h0000) ? 16'h0001 : seed;

    assign pack_shift = {pack, out_bit};
    assign pack_next  = pack_shift[WORD_W-1:0];
    assign flush_word = pack << (PK_FULL - pk_cnt);

    assign word_full = (pk_cnt == PK_LAST);
    assign out_free  = !word_valid || word_ready;
    // Only the word-completing bit needs the output register, so stall just that one.
    assign advance   = (state == S_RUN) && (remaining != '0)
                       && !(word_full && word_valid && !word_ready);

    assign busy = (state == S_RUN) || (state == S_FLUSH);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lfsr_state  <= 16'h0001;
            loaded_seed <= 16'h0001;
            remaining   <= '0;
            pk_cnt      <= '0;
            pack        <= '0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            period_wrap <= 1'b0;
        end else if (abort) begin
            state       <= S_IDLE;
            remaining   <= '0;
            pk_cnt      <= '0;
            pack        <= '0;
            word_valid  <= 1'b0;
            period_wrap <= 1'b0;
        end else begin
            period_wrap <= 1'b0;
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (nbits != '0) begin
                            lfsr_state  <= seed_eff;
                            loaded_seed <= seed_eff;
                            remaining   <= nbits;
                            pk_cnt      <= '0;
                            pack        <= '0;
                            state       <= S_RUN;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end

                S_RUN: begin
                    if (advance) begin
                        lfsr_state  <= lfsr_next;
                        period_wrap <= (lfsr_next == loaded_seed);
                        remaining   <= remaining - CNT_W'(1);
                        if (word_full) begin
                            word_data  <= pack_next;
                            word_valid <= 1'b1;
                            pk_cnt     <= '0;
                            pack       <= '0;
                        end else begin
                            pack   <= pack_next;
                            pk_cnt <= pk_cnt + 1'b1;
                        end
                        // The last bit always leaves either a partial word or a fresh valid word.
                        if (remaining == CNT_W'(1)) begin
                            state <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    if (pk_cnt != '0) begin
                        if (out_free) begin
                            word_data  <= flush_word;
                            word_valid <= 1'b1;
                            pk_cnt     <= '0;
                            pack       <= '0;
                        end
                    end else if (out_free) begin
                        state <= S_DONE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr16_stream_ctrl.sv
// tb/tb_lfsr16_stream_ctrl.sv - scoreboard bench for lfsr16_stream_ctrl
module tb_lfsr16_stream_ctrl;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       seed = 16'h0;
    logic [CNT_W-1:0]  nbits = '0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready = 1'b0;
    logic [15:0]       lfsr_state;
    logic              period_wrap;

    lfsr16_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .nbits      (nbits),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .lfsr_state (lfsr_state),
        .period_wrap(period_wrap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_q[$];
    int done_cnt = 0;
    int wrap_cnt = 0;
    int vrise_cnt = 0;
    int done_cyc = 0;
    int last_xfer_cyc = 0;
    int ready_mode = 0;
    int model_lfsr = 1;
    int exp_final = 1;
    int exp_wrap = 0;
    logic prev_valid = 1'b0;
    logic hold_chk = 1'b0;
    logic [WORD_W-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference LFSR step straight from the polynomial x^16+x^15+x^13+x^4+1.
    function automatic int adv(input int s);
        int f;
        f = ((s >> 15) ^ (s >> 14) ^ (s >> 12) ^ (s >> 3)) & 1;
        return ((s << 1) | f) & 32'hFFFF;
    endfunction

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) word_ready = 1'b1;
        else if (ready_mode == 1) word_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            hold_chk = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (period_wrap) wrap_cnt++;
            if (word_valid && !prev_valid) vrise_cnt++;
            if (hold_chk && word_valid) check("word_hold", word_data, held);
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", word_data);
                end else begin
                    check("word", word_data, exp_q.pop_front());
                end
                last_xfer_cyc = cyc;
                hold_chk = 1'b0;
            end else if (word_valid) begin
                held = word_data;
                hold_chk = 1'b1;
            end else begin
                hold_chk = 1'b0;
            end
            prev_valid = word_valid;
        end
    end

    task automatic expect_run(input int sd, input int n);
        int s, s0, w, k;
        exp_wrap = 0;
        exp_final = model_lfsr;
        if (n == 0) return;
        s0 = (sd == 0) ? 1 : sd;
        s = s0;
        w = 0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            w = (w << 1) | ((s >> 15) & 1);
            k++;
            if (k == WORD_W) begin
                exp_q.push_back(w);
                w = 0;
                k = 0;
            end
            s = adv(s);
            if (s == s0) exp_wrap++;
        end
        if (k > 0) exp_q.push_back(w << (WORD_W - k));
        exp_final = s;
    endtask

    task automatic start_run(input int sd, input int n);
        done_cnt = 0;
        wrap_cnt = 0;
        vrise_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        seed = 16'(sd);
        nbits = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input bit has_words);
        int t = 0;
        while (done_cnt == 0 && t < 80000) begin
            @(negedge clk); #1;
            t++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != 0), 1);
        check({name, "_busy_at_done"}, 32'(busy), 0);
        if (has_words) check({name, "_done_timing"}, done_cyc, last_xfer_cyc + 1);
        else check({name, "_no_words"}, vrise_cnt, 0);
        repeat (3) @(negedge clk);
        #1;
        check({name, "_done_once"}, done_cnt, 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_wraps"}, wrap_cnt, exp_wrap);
        check({name, "_final_lfsr"}, lfsr_state, exp_final);
        model_lfsr = exp_final;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_lfsr = 1;
        @(negedge clk);
        check("rst_lfsr", lfsr_state, 16'h0001);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", word_valid, 0);
        check("rst_wrap", period_wrap, 0);
        check("rst_data", word_data, 0);
    endtask

    initial begin
        int s, t;
        do_reset();

        ready_mode = 0;
        expect_run(16'h1234, 0);
        start_run(16'h1234, 0);
        finish_run("zero_bits", 1'b0);

        // Directed ordering/latency run, with a start pulse while busy that must be ignored.
        expect_run(16'hACE1, 16);
        start_run(16'hACE1, 16);
        @(negedge clk);
        check("e0_busy", busy, 1);
        check("e0_lfsr", lfsr_state, 16'hACE1);
        @(posedge clk); #1;
        start = 1'b1;
        seed = 16'h1234;
        nbits = CNT_W'(5);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("valid_before_e8", word_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("valid_after_e8", word_valid, 1);
        finish_run("ace1_16", 1'b1);

        // Backpressure: hold ready low once the first word is up.
        ready_mode = 2;
        word_ready = 1'b0;
        expect_run(16'hACE1, 16);
        start_run(16'hACE1, 16);
        t = 0;
        while (!word_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", word_valid, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        s = 16'hACE1;
        for (int i = 0; i < 15; i++) s = adv(s);
        check("bp_lfsr_frozen", lfsr_state, s);
        check("bp_word_held", word_data, 8'hAC);
        @(posedge clk); #1;
        word_ready = 1'b1;
        ready_mode = 0;
        finish_run("backpressure", 1'b1);

        expect_run(16'hACE1, 12);
        start_run(16'hACE1, 12);
        finish_run("partial", 1'b1);

        // Abort after five advances.
        ready_mode = 0;
        start_run(16'hACE1, 16);
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        s = 16'hACE1;
        for (int i = 0; i < 5; i++) s = adv(s);
        check("abort_busy", busy, 0);
        check("abort_valid", word_valid, 0);
        check("abort_lfsr", lfsr_state, s);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_words", vrise_cnt, 0);
        check("abort_lfsr_hold", lfsr_state, s);
        model_lfsr = s;

        expect_run(16'hACE1, 16);
        start_run(16'hACE1, 16);
        finish_run("restart", 1'b1);

        for (int r = 0; r < 8; r++) begin
            int sd, n;
            ready_mode = 1;
            sd = (r == 0) ? 0 : int'($urandom_range(0, 16'hFFFF));
            n = $urandom_range(1, 60);
            expect_run(sd, n);
            start_run(sd, n);
            finish_run("random", 1'b1);
        end

        // Reset in the middle of a run.
        ready_mode = 1;
        expect_run(16'hBEEF, 40);
        start_run(16'hBEEF, 40);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_lfsr = 1;
        @(negedge clk);
        check("midrst_lfsr", lfsr_state, 16'h0001);
        check("midrst_valid", word_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", word_data, 0);

        ready_mode = 0;
        expect_run(16'h0000, 65535);
        start_run(16'h0000, 65535);
        finish_run("full_period", 1'b1);
        check("full_period_lfsr", lfsr_state, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr16_stream_ctrl.md
# lfsr16_stream_ctrl

Sequencer for the 16-bit Fibonacci LFSR generator. It seeds the LFSR, runs it for a programmed number of output bits, and packs the serial output bit into WORD_W-bit words. Words go out on a valid/ready stream, and the LFSR stalls under backpressure. It replaces the free-running "dump bit 16 every cycle" usage with a bounded, restartable, flow-controlled bit source for the capture and statistics blocks downstream.

## Interface
- WORD_W, 8: packed word width, legal 1..16.
- CNT_W, 24: width of the bit-count field.

- clk, in, 1: the single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a run; sampled only in IDLE.
- seed, in, 16: LFSR seed, sampled with start.
- nbits, in, CNT_W: number of LFSR output bits to produce, sampled with start.
- abort, in, 1: terminate the run; wins over everything except rst.
- busy, out, 1: high in RUN and FLUSH.
- done, out, 1: one-cycle pulse at normal run completion.
- word_data, out, WORD_W: packed word, first-generated bit in MSB.
- word_valid, out, 1: word_data is valid.
- word_ready, in, 1: consumer accepts; transfer on valid && ready at a rising edge.
- lfsr_state, out, 16: current LFSR register, bits [16:1].
- period_wrap, out, 1: one-cycle pulse when an advance returns the state to the loaded seed.

## Operation
- LFSR polynomial is x^16+x^15+x^13+x^4+1 (maximal, period 65535).
  - fb = s[16]^s[15]^s[13]^s[4].
  - Advance: s <= {s[15:1], fb}.
  - Output bit is s[16] before the advance.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 && nbits!=0: lfsr_state<=seed, or 16'h0001 when seed==0; remaining<=nbits; pack cleared; go to RUN.
  - start=1 && nbits==0: go to DONE directly; no words are produced.
- RUN:
  - advance = (remaining!=0) && !(pk_cnt==WORD_W-1 && word_valid && !word_ready).
  - On each advance, out bit enters the pack register MSB-first, remaining decrements, and pk_cnt increments.
  - On the WORD_W-th bit, the full word moves to the output register (word_valid<=1) and pk_cnt<=0.
  - When remaining reaches 0: go to FLUSH if a partial word is held (pk_cnt!=0) or word_valid is still set; otherwise go to DONE.
- FLUSH:
  - A partial word moves to the output register as soon as it is free (!word_valid || word_ready). Unused low bits are 0.
  - Go to DONE at the edge where the last word is accepted.
- DONE: done=1 for exactly one cycle, then IDLE.
- start in any state other than IDLE is ignored; nothing is queued.
- abort=1 at any edge:
  - Next state is IDLE; word_valid, pack register, pk_cnt and remaining are cleared.
  - lfsr_state is retained; done is not pulsed.
- period_wrap compares against the seed as actually loaded (the 0x0001 substitute when seed==0). It fires only on advancing edges.
- The LFSR holds its value whenever it is not advancing.

## Timing
- Reset values:
  - State IDLE; lfsr_state=16'h0001.
  - busy, done, word_valid and period_wrap = 0.
  - word_data=0; pk_cnt=0; remaining=0.
- All outputs are registered; there are no combinational input-to-output paths.
- start is sampled at edge E0. busy=1 and lfsr_state=seed are visible after E0; the first advance happens at E1.
- With no backpressure, word k (k≥1) becomes valid after edge E(k·WORD_W).
- Throughput is one bit per cycle. There are no bubbles while word_ready=1.
- word_data is stable while word_valid && !word_ready.
- done is high the cycle after the final transfer edge; busy is low in that same cycle.
- rst mid-run returns every register to its reset value at that edge.

## Test plan
- Reset behaviour: assert rst for 2 cycles, then release → lfsr_state=0x0001, all outputs 0, state IDLE; start with nbits=0 → done pulses once, word_valid never rises.
- Seed output order: seed=0xACE1, nbits=16, WORD_W=8, word_ready=1 → words 0xAC then 0xE1, valid after E8 and E16; done pulses 1 cycle after the 0xE1 transfer.
- Backpressure stall:
  - Stimulus: same run with word_ready=0 for 20 cycles once 0xAC is valid.
  - Response: word_data holds 0xAC; lfsr_state freezes after 15 total advances.
  - After release: 0xAC then 0xE1 are delivered with no lost or duplicated bits.
- Partial final word: seed=0xACE1, nbits=12 → words 0xAC and 0xE0 (zero-padded); FLUSH is entered; done pulses once.
- Full period:
  - seed=0x0000 (loaded as 0x0001), nbits=65535, WORD_W=16, word_ready=1.
  - period_wrap pulses exactly once, at the 65535th advance; lfsr_state=0x0001 at done.
- Abort and restart:
  - abort at bit 5 of a 16-bit run → IDLE next edge, word_valid=0, no done pulse, lfsr_state holds its value.
  - start asserted while busy is ignored.
  - A fresh start afterwards reproduces 0xAC, 0xE1 for seed 0xACE1.
